// File: rtl/misaligned_access_unit_pkg.sv
// Shared types and helpers for the load/store alignment path.
package mem_access_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } mau_state_t;

    function automatic int unsigned size_bytes(access_size_t size);
        return 32'd1 << size;
    endfunction

    function automatic logic size_legal(access_size_t size, int unsigned bytes);
        return size_bytes(size) <= bytes;
    endfunction

endpackage

// File: rtl/misaligned_access_unit_lane_mask_gen.sv
// Byte-lane mask across two consecutive memory words, plus the word-crossing flag.
module lane_mask_gen
    import mem_access_pkg::*;
#(
    parameter int unsigned BYTES = 4,
    localparam int unsigned OFF_W = $clog2(BYTES)
)
(
    input  logic [OFF_W-1:0]   off,
    input  logic [1:0]         size,
    output logic [2*BYTES-1:0] mask,
    output logic               split
);

    int unsigned first;
    int unsigned last;

    always_comb begin
        first = 32'(off);
        last  = first + size_bytes(access_size_t'(size));
        mask  = '0;
        for (int unsigned i = 0; i < 2 * BYTES; i++) begin
            mask[i] = (i >= first) && (i < last);
        end
        split = last > BYTES;
    end

endmodule

// File: rtl/misaligned_access_unit.sv
// Load/store alignment unit: splits word-crossing accesses into two beats and
// right-justifies and extends load data.
module misaligned_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_unsigned,
    input  logic [1:0]              req_size,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error,
    output logic                    mem_req,
    input  logic                    mem_ack,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_byte_select,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    mau_state_t              state_q, state_d;
    logic                    write_q, unsigned_q, error_q;
    access_size_t            size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [2*DATA_WIDTH-1:0] rbuf_q;

    logic [OFF_W-1:0]        off;
    logic [2*BYTES-1:0]      mask;
    logic                    split;
    logic [2*DATA_WIDTH-1:0] wvec;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [DATA_WIDTH-1:0]   shifted, load_data;
    logic                    sign;
    int unsigned             nbits;

    // All beat fields derive from captured request state, never from req_* directly.
    assign off       = addr_q[OFF_W-1:0];
    assign base_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign wvec      = {{DATA_WIDTH{1'b0}}, wdata_q} << {off, 3'b000};

    lane_mask_gen #(.BYTES(BYTES)) u_lane_mask_gen (
        .off   (off),
        .size  (size_q),
        .mask  (mask),
        .split (split)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        mem_req         = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_byte_select = '0;
        mem_wdata       = '0;
        resp_valid      = 1'b0;
        resp_error      = 1'b0;
        resp_rdata      = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = size_legal(access_size_t'(req_size), BYTES) ? BEAT0 : RESP;
                end
            end
            BEAT0: begin
                mem_req         = 1'b1;
                mem_write       = write_q;
                mem_addr        = base_addr;
                mem_byte_select = mask[BYTES-1:0];
                mem_wdata       = wvec[DATA_WIDTH-1:0];
                if (mem_ack) state_d = split ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_req         = 1'b1;
                mem_write       = write_q;
                mem_addr        = base_addr + ADDR_WIDTH'(BYTES);
                mem_byte_select = mask[2*BYTES-1:BYTES];
                mem_wdata       = wvec[2*DATA_WIDTH-1:DATA_WIDTH];
                if (mem_ack) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = error_q;
                resp_rdata = (write_q || error_q) ? '0 : load_data;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            error_q    <= 1'b0;
            size_q     <= BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                error_q    <= !size_legal(access_size_t'(req_size), BYTES);
                size_q     <= access_size_t'(req_size);
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
            end
            if (state_q == BEAT0 && mem_ack) rbuf_q[DATA_WIDTH-1:0] <= mem_rdata;
            if (state_q == BEAT1 && mem_ack) rbuf_q[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_rdata;
        end
    end

    always_comb begin
        shifted = DATA_WIDTH'(rbuf_q >> {off, 3'b000});
        nbits   = 8 * size_bytes(size_q);
        case (size_q)
            BYTE:    sign = shifted[7];
            HALF:    sign = shifted[15];
            WORD:    sign = shifted[31];
            default: sign = shifted[DATA_WIDTH-1];
        endcase
        load_data = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            load_data[i] = (i < nbits) ? shifted[i] : (!unsigned_q && sign);
        end
    end

endmodule
